// File: rtl/booth_mult_scheduler.sv
// booth_mult_scheduler
// Shares one 4x4 signed Booth multiplier between two requesters.
// A request is granted in IDLE, its operands are latched, the multiplier
// is started for one cycle (ISSUE), the product is awaited (WAIT) with a
// timeout, and the owning requester gets a one-cycle done pulse (RETURN).
//
// Handshake contract (both requesters and the multiplier side):
//   - reqN is a level request; it is only looked at while the block is IDLE
//     and the requester holds it until it sees doneN, then drops it.
//   - gntN is high from ISSUE through RETURN for the owning requester only.
//   - doneN is a single-cycle pulse; pN is valid from that cycle on and holds
//     until the same requester completes again.
//   - mul_start is a single-cycle pulse carrying mul_a/mul_b; mul_ready is a
//     single-cycle pulse carrying mul_p and is only honoured in WAIT.
module booth_mult_scheduler #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  output logic       gnt0,
  output logic       done0,
  output logic [7:0] p0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt1,
  output logic       done1,
  output logic [7:0] p1,
  output logic       mul_start,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_p,
  input  logic       mul_ready,
  output logic       busy,
  output logic       err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;   // requester currently being served
  logic       last_q,  last_d;    // requester served most recently
  logic [3:0] op_a_q,  op_a_d;
  logic [3:0] op_b_q,  op_b_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [7:0] p0_q,    p0_d;
  logic [7:0] p1_q,    p1_d;
  logic       err_q,   err_d;

  logic any_req;
  logic pick;
  logic timeout_hit;

  // Round-robin choice: on a contest the requester not served last wins;
  // otherwise whoever is asking.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      pick = ~last_q;
    end else begin
      pick = req1;
    end
    timeout_hit = (cnt_q == CNT_LAST);
  end

  // State register and all datapath flops; reset aborts any operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_a_q  <= 4'd0;
      op_b_q  <= 4'd0;
      cnt_q   <= 8'd0;
      p0_q    <= 8'd0;
      p1_q    <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a product arriving in the last WAIT cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_ready || timeout_hit) state_d = S_RETURN;
      end
      S_RETURN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath updates: grant/latch in IDLE, counter in WAIT, pointer in RETURN.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cnt_d   = cnt_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = pick;
          op_a_d  = pick ? a1 : a0;
          op_b_d  = pick ? b1 : b0;
        end
      end
      S_ISSUE: begin
        cnt_d = 8'd0;
      end
      S_WAIT: begin
        if (mul_ready) begin
          if (owner_q) p1_d = mul_p;
          else         p0_d = mul_p;
        end else if (timeout_hit) begin
          if (owner_q) p1_d = 8'd0;
          else         p0_d = 8'd0;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RETURN: begin
        last_d = owner_q;
      end
      default: begin
        cnt_d = 8'd0;
      end
    endcase
  end

  // Outputs decoded from the registered state and owner only.
  always_comb begin
    mul_start = (state_q == S_ISSUE);
    busy      = (state_q != S_IDLE);
    gnt0      = busy & ~owner_q;
    gnt1      = busy &  owner_q;
    done0     = (state_q == S_RETURN) & ~owner_q;
    done1     = (state_q == S_RETURN) &  owner_q;
    mul_a     = op_a_q;
    mul_b     = op_b_q;
    p0        = p0_q;
    p1        = p1_q;
    err       = err_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Bench for booth_mult_scheduler: behavioural multiplier with programmable
// latency, transaction-level scoreboard of {requester, product}, table of
// directed operations, random request groups and multi-cycle corner cases.
module tb_booth_mult_scheduler;

  localparam int T = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] p0, p1;
  logic       mul_start;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_p = 8'd0;
  logic       mul_ready = 1'b0;
  logic       busy, err;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  logic last_served = 1'b1;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;
  vec_t tbl[8];

  booth_mult_scheduler #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0), .p0(p0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1), .p1(p1),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_ready(mul_ready),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r = sa * sb;
    return r[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Behavioural multiplier: product appears mul_lat cycles after the start pulse.
  logic mul_en = 1'b1;
  int   mul_lat = 4;
  int   mul_cnt = 0;
  logic [7:0] mul_res = 8'd0;
  always @(posedge clock) begin
    #1;
    mul_ready = 1'b0;
    if (!reset) begin
      mul_cnt = 0;
    end else begin
      if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0) begin
          mul_ready = 1'b1;
          mul_p = mul_res;
        end
      end
      if (mul_start && mul_en) begin
        mul_cnt = mul_lat;
        mul_res = prod(mul_a, mul_b);
      end
    end
  end

  // Scoreboard and protocol monitor, sampled on the falling edge.
  logic prev_done = 1'b0;
  always @(negedge clock) begin
    logic [8:0] e;
    if (!reset) begin
      prev_done = 1'b0;
    end else begin
      check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
      check("start_has_gnt", {31'd0, mul_start & ~(gnt0 | gnt1)}, 32'd0);
      if (done0 || done1) begin
        check("done_single_cycle", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", done0, done1);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", {23'd0, done1, (done1 ? p1 : p0)}, {23'd0, e});
        end
      end
      prev_done = done0 | done1;
    end
  end

  // driver: one operation by a single requester with cycle-exact checks
  task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp_p, input int exp_k, input logic exp_err,
                       input string name);
    int   k = 0;
    int   k_start = -1;
    int   k_done = -1;
    logic other_gnt = 1'b0;
    logic [3:0] seen_a = 4'd0, seen_b = 4'd0;
    exp_q.push_back({id, exp_p});
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; end
    while (k_done < 0 && k < 60) begin
      tick();
      k++;
      if (k == 1) begin
        a0 = 4'($urandom); b0 = 4'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom);
      end
      if (mul_start && k_start < 0) begin
        k_start = k;
        seen_a = mul_a;
        seen_b = mul_b;
      end
      if (id ? gnt0 : gnt1) other_gnt = 1'b1;
      if (id ? done1 : done0) begin
        k_done = k;
        if (id) req1 = 1'b0; else req0 = 1'b0;
        check({name, "_p"}, {24'd0, (id ? p1 : p0)}, {24'd0, exp_p});
        check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
      end
    end
    check({name, "_start_cycle"}, k_start, 1);
    check({name, "_mul_ab"}, {24'd0, seen_a, seen_b}, {24'd0, a, b});
    check({name, "_done_cycle"}, k_done, exp_k);
    check({name, "_other_gnt"}, {31'd0, other_gnt}, 32'd0);
    last_served = id;
    tick();
    check({name, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  // driver: one or two simultaneous requests, order predicted by round-robin rule
  task automatic run_group(input logic r0, input logic r1,
                           input logic [3:0] xa0, input logic [3:0] xb0,
                           input logic [3:0] xa1, input logic [3:0] xb1);
    logic first;
    logic pend0, pend1;
    int   k = 0;
    if (r0 && r1) begin
      first = ~last_served;
      exp_q.push_back({first, first ? prod(xa1, xb1) : prod(xa0, xb0)});
      exp_q.push_back({~first, ~first ? prod(xa1, xb1) : prod(xa0, xb0)});
      last_served = ~first;
    end else if (r0) begin
      exp_q.push_back({1'b0, prod(xa0, xb0)});
      last_served = 1'b0;
    end else begin
      exp_q.push_back({1'b1, prod(xa1, xb1)});
      last_served = 1'b1;
    end
    a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    req0 = r0; req1 = r1;
    pend0 = r0; pend1 = r1;
    while ((pend0 || pend1) && k < 80) begin
      tick();
      k++;
      if (done0) begin req0 = 1'b0; pend0 = 1'b0; end
      if (done1) begin req1 = 1'b0; pend1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("group_complete", {30'd0, pend0, pend1}, 32'd0);
    tick();
  endtask

  // driver: both requests held high for n operations
  task automatic run_alt(input int n);
    logic [3:0] xa0, xb0, xa1, xb1;
    logic nid;
    int   seen = 0, k = 0, last_k = -1;
    xa0 = 4'($urandom); xb0 = 4'($urandom);
    xa1 = 4'($urandom); xb1 = 4'($urandom);
    for (int i = 0; i < n; i++) begin
      nid = ~last_served;
      exp_q.push_back({nid, nid ? prod(xa1, xb1) : prod(xa0, xb0)});
      last_served = nid;
    end
    a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    req0 = 1'b1; req1 = 1'b1;
    while (seen < n && k < 200) begin
      tick();
      k++;
      if (done0 || done1) begin
        seen++;
        if (last_k < 0) check("alt_first_done", k, 6);
        else            check("alt_gap", k - last_k, 7);
        last_k = k;
        if (seen == n) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("alt_count", seen, n);
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_gnt"},   {30'd0, gnt0, gnt1}, 32'd0);
    check({name, "_done"},  {30'd0, done0, done1}, 32'd0);
    check({name, "_start"}, {31'd0, mul_start}, 32'd0);
    check({name, "_busy"},  {31'd0, busy}, 32'd0);
    check({name, "_err"},   {31'd0, err}, 32'd0);
    check({name, "_p"},     {16'd0, p0, p1}, 32'd0);
    check({name, "_mul_ab"}, {24'd0, mul_a, mul_b}, 32'd0);
    check({name, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    logic [1:0] pat;
    tbl[0] = '{1'b0, 4'd3,  4'hE, 8'hFA};
    tbl[1] = '{1'b1, 4'd7,  4'hF, 8'hF9};
    tbl[2] = '{1'b0, 4'h8,  4'h8, 8'h40};
    tbl[3] = '{1'b1, 4'h8,  4'd7, 8'hC8};
    tbl[4] = '{1'b0, 4'd0,  4'd5, 8'h00};
    tbl[5] = '{1'b1, 4'hF,  4'hF, 8'h01};
    tbl[6] = '{1'b0, 4'd7,  4'd7, 8'h31};
    tbl[7] = '{1'b1, 4'd5,  4'hD, 8'hF1};

    reset = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    last_served = 1'b1;
    tick();
    tick();
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    // Table of single operations; entry 0 is the first operation after reset.
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p, 6, 1'b0, $sformatf("tbl%0d", i));
    end

    // Both requests held: strict alternation.
    run_alt(8);

    // Random request groups against the round-robin model.
    for (int i = 0; i < 20; i++) begin
      pat = 2'($urandom_range(1, 3));
      run_group(pat[0], pat[1], 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    // Product in the last WAIT cycle wins over the timeout.
    do_op(1'b1, 4'd7, 4'd7, 8'h31, 6, 1'b0, "pre_to");
    mul_lat = T;
    do_op(1'b0, 4'd3, 4'd3, 8'h09, 2 + T, 1'b0, "ready_last");
    // One cycle later is too late: timeout, late pulse ignored in RETURN.
    mul_lat = T + 1;
    do_op(1'b0, 4'd3, 4'd3, 8'h00, 2 + T, 1'b1, "ready_late");
    mul_lat = 4;
    // Multiplier never answers.
    mul_en = 1'b0;
    do_op(1'b1, 4'd2, 4'd5, 8'h00, 2 + T, 1'b1, "timeout");
    mul_en = 1'b1;
    // err stays set across a normal completion.
    do_op(1'b0, 4'd2, 4'd3, 8'h06, 6, 1'b1, "sticky_err");

    // Reset pulsed in WAIT: immediate abort, no done.
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd3;
    repeat (3) tick();
    check("pre_abort_state", {30'd0, dbg_state}, 32'd2);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    req0 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    last_served = 1'b1;
    repeat (10) tick();
    check("abort_idle", {31'd0, busy}, 32'd0);

    // Contest right after reset: requester 0 first.
    run_group(1'b1, 1'b1, 4'h8, 4'h8, 4'd7, 4'hF);
    check("contest_p0", {24'd0, p0}, 32'h40);
    check("contest_p1", {24'd0, p1}, 32'hF9);

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
